// File: rtl/vga_timing_out.sv
// VGA raster timing generator with a one-pixel registered colour/sync/blank
// output stage for the DAC.
module vga_timing_out #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] red_in,
    input  logic [9:0] green_in,
    input  logic [9:0] blue_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_en,
    output logic       frame_tick,
    output logic       vga_clk,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic [9:0] vga_r,
    output logic [9:0] vga_g,
    output logic [9:0] vga_b
);

    localparam int unsigned CW       = 10;
    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             x_last;
    logic             y_last;
    logic             visible;
    logic             hs_on;
    logic             vs_on;

    // Divider wraps at CLK_DIV-1
    always_comb begin
        div_nxt = div + 1'b1;
        if (div == DIV_W'(CLK_DIV - 1)) begin
            div_nxt = '0;
        end
    end

    // Decode of the current (pre-advance) raster position
    always_comb begin
        x_last  = (x == CW'(H_TOTAL - 1));
        y_last  = (y == CW'(V_TOTAL - 1));
        visible = (x < CW'(H_ACTIVE)) && (y < CW'(V_ACTIVE));
        hs_on   = (x >= CW'(HS_START)) && (x < CW'(HS_END));
        vs_on   = (y >= CW'(VS_START)) && (y < CW'(VS_END));
    end

    // pix_en and vga_clk are registered from the next divider value so they
    // describe the divider phase of the cycle they are visible in
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div     <= '0;
            pix_en  <= 1'b0;
            vga_clk <= 1'b0;
        end else begin
            div     <= div_nxt;
            pix_en  <= (div_nxt == DIV_W'(CLK_DIV - 1));
            vga_clk <= (div_nxt >= DIV_W'(CLK_DIV / 2));
        end
    end

    // Raster counters and frame tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x          <= '0;
            y          <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pix_en && x_last && y_last;
            if (pix_en) begin
                if (x_last) begin
                    x <= '0;
                    if (y_last) begin
                        y <= '0;
                    end else begin
                        y <= y + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    // Output stage: one pixel behind x/y, sync/blank/colour kept aligned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else if (pix_en) begin
            vga_hs      <= !hs_on;
            vga_vs      <= !vs_on;
            vga_blank_n <= visible;
            vga_r       <= visible ? red_in   : '0;
            vga_g       <= visible ? green_in : '0;
            vga_b       <= visible ? blue_in  : '0;
        end
    end

endmodule
